// File: rtl/npu_pkg.sv
// Shared NPU definitions: reader FSM states, default widths and the image
// geometry that the image RAM and the max-pool reader must agree on.
package npu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_L,
        FETCH_R,
        EMIT
    } state_t;

    localparam int NPU_DATA_W = 8;
    localparam int NPU_ADDR_W = 10;

    localparam int IMG_ROWS = 28;
    localparam int IMG_COLS = 28;

endpackage

// File: rtl/maxpool_max2.sv
// Combinational unsigned maximum of two pixels.
module maxpool_max2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = (a >= b) ? a : b;

endmodule

// File: rtl/maxpool_reader.sv
// 2x2 max-pool reader: walks the image RAM window by window over two read
// ports and streams one pooled pixel per window. MAXPOOL_COORD_EN adds
// registered out_row/out_col coordinates alongside out_data.
module maxpool_reader
    import npu_pkg::*;
#(
    parameter int ROWS   = IMG_ROWS,
    parameter int COLS   = IMG_COLS,
    parameter int ADDR_W = NPU_ADDR_W,
    parameter int DATA_W = NPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MAXPOOL_COORD_EN
    ,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col
`endif
);

    // An odd trailing row/column never forms a full window and is skipped.
    localparam int ROWS_E = ROWS - (ROWS % 2);
    localparam int COLS_E = COLS - (COLS % 2);
    localparam int RW     = $clog2(ROWS_E + 2);
    localparam int CW     = $clog2(COLS_E + 2);

    state_t            state;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic [DATA_W-1:0] left_max;

    logic [DATA_W-1:0] pair_l;
    logic [DATA_W-1:0] pair_r;
    logic [DATA_W-1:0] win_max;

    logic [ADDR_W-1:0] base;
    logic              last_col;
    logic              last_row;
    logic              handshake;

    maxpool_max2 #(.DATA_W(DATA_W)) u_max_l (
        .a (data_in1),
        .b (data_in2),
        .y (pair_l)
    );

    maxpool_max2 #(.DATA_W(DATA_W)) u_max_r (
        .a (data_in1),
        .b (data_in2),
        .y (pair_r)
    );

    maxpool_max2 #(.DATA_W(DATA_W)) u_max_f (
        .a (left_max),
        .b (pair_r),
        .y (win_max)
    );

    // Top-left address of the current window; truncation to ADDR_W is safe
    // because the whole image fits in the RAM address space.
    assign base      = ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    assign last_col  = (int'(c) + 2 >= COLS_E);
    assign last_row  = (int'(r) + 2 >= ROWS_E);
    assign handshake = (state == EMIT) && out_valid && out_ready;

    // Addresses are decoded straight from registered state so the RAM data
    // returns within the same fetch cycle; idle/stall cycles present 0.
    always_comb begin
        rd_addr1 = '0;
        rd_addr2 = '0;
        if (state == FETCH_L) begin
            rd_addr1 = base;
            rd_addr2 = base + ADDR_W'(COLS);
        end else if (state == FETCH_R) begin
            rd_addr1 = base + ADDR_W'(1);
            rd_addr2 = base + ADDR_W'(COLS) + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            left_max  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef MAXPOOL_COORD_EN
            out_row   <= '0;
            out_col   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse waits a cycle.
                    if (start && !done) begin
                        state <= FETCH_L;
                        r     <= '0;
                        c     <= '0;
                        busy  <= 1'b1;
                    end
                end
                FETCH_L: begin
                    left_max <= pair_l;
                    state    <= FETCH_R;
                end
                FETCH_R: begin
                    out_data  <= win_max;
                    out_valid <= 1'b1;
`ifdef MAXPOOL_COORD_EN
                    out_row   <= 4'(r >> 1);
                    out_col   <= 4'(c >> 1);
`endif
                    state     <= EMIT;
                end
                EMIT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (last_col) begin
                            c <= '0;
                            r <= r + RW'(2);
                        end else begin
                            c <= c + CW'(2);
                        end
                        if (last_col && last_row) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH_L;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
